// File: rtl/dmem_access_ctrl.sv
// Data-memory port sequencer: arbitrates MEM-stage and debug accesses onto one
// variable-latency memory port, stalls the pipeline and aborts bad or hung accesses.
module dmem_access_ctrl #(
  parameter int TIMEOUT      = 64,
  parameter int MAX_CPU_WINS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWriteM,
  input  logic        memToRegM,
  input  logic [31:0] aluOutM,
  input  logic [31:0] writeDataM,
  output logic        stallM,
  output logic [31:0] readDataM,
  output logic        readValidM,
  input  logic        dbgReq,
  input  logic        dbgWe,
  input  logic [31:0] dbgAddr,
  input  logic [31:0] dbgWdata,
  output logic        dbgAck,
  output logic [31:0] dbgRdata,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        busErr
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int WIN_W = $clog2(MAX_CPU_WINS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(MAX_CPU_WINS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WAIT = 2'd1,
    DBG_WAIT = 2'd2,
    CPU_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_bus_err;
  logic [31:0]      r_read_data;
  logic             r_read_valid;
  logic             r_dbg_ack;
  logic [31:0]      r_dbg_rdata;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic w_cpu_acc;
  logic w_dbg_pend;
  logic w_win_sat;
  logic w_dbg_grant;
  logic w_cpu_grant;
  logic w_cpu_misalign;
  logic w_dbg_misalign;
  logic w_tmo;

  assign w_cpu_acc      = memWriteM | memToRegM;
  // dbgReq is still high in the cycle its dbgAck is presented; that is not a new request
  assign w_dbg_pend     = dbgReq & ~r_dbg_ack;
  assign w_win_sat      = (r_win_cnt == WIN_MAX);
  assign w_dbg_grant    = (r_state == IDLE) & w_dbg_pend & (~w_cpu_acc | w_win_sat);
  assign w_cpu_grant    = (r_state == IDLE) & w_cpu_acc & ~w_dbg_grant;
  assign w_cpu_misalign = |aluOutM[1:0];
  assign w_dbg_misalign = |dbgAddr[1:0];
  assign w_tmo          = (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_win_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_bus_err    <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_dbg_rdata  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_dbg_ack    <= 1'b0;
      r_read_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dbg_grant) begin
            r_win_cnt <= '0;
            if (w_dbg_misalign) begin
              r_bus_err   <= 1'b1;
              r_dbg_ack   <= 1'b1;
              r_dbg_rdata <= '0;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= dbgWe;
              r_mem_addr  <= dbgAddr;
              r_mem_wdata <= dbgWdata;
              r_tmo_cnt   <= '0;
              r_state     <= DBG_WAIT;
            end
          end else if (w_cpu_grant) begin
            if (w_dbg_pend && !w_win_sat) begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
            end
            if (w_cpu_misalign) begin
              r_bus_err    <= 1'b1;
              r_read_data  <= '0;
              r_read_valid <= 1'b1;
              r_state      <= CPU_DONE;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= memWriteM;
              r_mem_addr  <= aluOutM;
              r_mem_wdata <= writeDataM;
              r_tmo_cnt   <= '0;
              r_state     <= CPU_WAIT;
            end
          end
        end

        CPU_WAIT: begin
          if (memAck) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_read_data  <= r_mem_we ? 32'd0 : memRdata;
            r_read_valid <= 1'b1;
            r_tmo_cnt    <= '0;
            r_state      <= CPU_DONE;
          end else if (w_tmo) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_bus_err    <= 1'b1;
            r_read_data  <= '0;
            r_read_valid <= 1'b1;
            r_tmo_cnt    <= '0;
            r_state      <= CPU_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end

        DBG_WAIT: begin
          if (memAck) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_dbg_ack   <= 1'b1;
            r_dbg_rdata <= memRdata;
            r_tmo_cnt   <= '0;
            r_state     <= IDLE;
          end else if (w_tmo) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_bus_err   <= 1'b1;
            r_dbg_ack   <= 1'b1;
            r_dbg_rdata <= '0;
            r_tmo_cnt   <= '0;
            r_state     <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end

        // Pipeline advances on this edge; re-arbitrate only once back in IDLE
        CPU_DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stallM     = w_cpu_acc & (r_state != CPU_DONE) & ~rst;
  assign readDataM  = r_read_data;
  assign readValidM = r_read_valid;
  assign dbgAck     = r_dbg_ack;
  assign dbgRdata   = r_dbg_rdata;
  assign memReq     = r_mem_req;
  assign memWe      = r_mem_we;
  assign memAddr    = r_mem_addr;
  assign memWdata   = r_mem_wdata;
  assign busErr     = r_bus_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a latency-programmable memory model answers
// requests while expected completion data queued at stimulus time is checked on output.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        memWriteM, memToRegM;
  logic [31:0] aluOutM, writeDataM;
  logic        stallM;
  logic [31:0] readDataM;
  logic        readValidM;
  logic        dbgReq, dbgWe;
  logic [31:0] dbgAddr, dbgWdata;
  logic        dbgAck;
  logic [31:0] dbgRdata;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memAck;
  logic        busErr;

  logic        mdl_ack, inj_ack;
  int          mem_lat;
  bit          mem_never;
  logic [31:0] mem_arr [256];

  int          n_tests, n_fail;
  int          valid_cnt, dbg_cnt, n_cpu_exp, n_dbg_exp;
  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];

  assign memAck = mdl_ack | inj_ack;

  dmem_access_ctrl #(.TIMEOUT(64), .MAX_CPU_WINS(4)) dut (
    .clk(clk), .rst(rst),
    .memWriteM(memWriteM), .memToRegM(memToRegM),
    .aluOutM(aluOutM), .writeDataM(writeDataM),
    .stallM(stallM), .readDataM(readDataM), .readValidM(readValidM),
    .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
    .dbgAck(dbgAck), .dbgRdata(dbgRdata),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck), .busErr(busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: acks in the mem_lat-th cycle of memReq, returns array contents
  initial begin : mem_model
    int          age;
    logic        ack_we;
    logic [7:0]  ack_idx;
    logic [31:0] ack_wdata;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA000_0000 | 32'(i);
    mem_arr[8'h04] = 32'hCAFE_F00D;
    mem_arr[8'h20] = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) mem_arr[8'h10 + i] = 32'h1111_0000 + 32'(i);
    age = 0; ack_we = 0; ack_idx = 0; ack_wdata = 0;
    mdl_ack = 1'b0; memRdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (mdl_ack && ack_we) mem_arr[ack_idx] = ack_wdata;
      #1;
      if (memReq === 1'b1) age++; else age = 0;
      mdl_ack = (memReq === 1'b1) && !mem_never && (age == mem_lat);
      if (mdl_ack) begin
        ack_we    = memWe;
        ack_idx   = memAddr[9:2];
        ack_wdata = memWdata;
        memRdata  = mem_arr[memAddr[9:2]];
      end else begin
        ack_we   = 1'b0;
        memRdata = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (readValidM === 1'b1) begin
        valid_cnt++;
        $display("[TB] cpu complete  rdata=0x%08h busErr=%0b", readDataM, busErr);
        if (cpu_q.size() == 0) check("cpu_unexpected", 32'(cpu_q.size()), 32'd1);
        else begin
          e = cpu_q.pop_front();
          check("cpu_rdata", readDataM, e);
        end
      end
      if (dbgAck === 1'b1) begin
        dbg_cnt++;
        $display("[TB] dbg complete  rdata=0x%08h busErr=%0b", dbgRdata, busErr);
        if (dbg_q.size() == 0) check("dbg_unexpected", 32'(dbg_q.size()), 32'd1);
        else begin
          e = dbg_q.pop_front();
          check("dbg_rdata", dbgRdata, e);
        end
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input int exp_stall, input int exp_req,
                            input string tag);
    int stall_n, req_n, we_n, wd_bad;
    bit done;
    cpu_q.push_back(exp_rd);
    n_cpu_exp++;
    memWriteM = we; memToRegM = ~we; aluOutM = addr; writeDataM = wdata;
    stall_n = 0; req_n = 0; we_n = 0; wd_bad = 0; done = 0;
    #1;
    if (stallM) stall_n++;
    if (memReq) req_n++;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk); #1;
      if (stallM) stall_n++;
      if (memReq) begin
        req_n++;
        if (memWe) begin
          we_n++;
          if (memWdata !== wdata || memAddr !== addr) wd_bad++;
        end
      end
      if (readValidM) done = 1;
    end
    memWriteM = 1'b0; memToRegM = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall"}, 32'(stall_n), 32'(exp_stall));
    check({tag, "_req"}, 32'(req_n), 32'(exp_req));
    check({tag, "_we"}, 32'(we_n), we ? 32'(exp_req) : 32'd0);
    if (we) check({tag, "_wdata"}, 32'(wd_bad), 32'd0);
  endtask

  task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, output int cyc);
    bit got;
    dbg_q.push_back(exp_rd);
    n_dbg_exp++;
    dbgReq = 1'b1; dbgWe = we; dbgAddr = addr; dbgWdata = wdata;
    cyc = 0; got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      cyc++;
      if (dbgAck) got = 1;
    end
    dbgReq = 1'b0;
    check("dbg_ack_seen", 32'(got), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int cyc, base, dbg_at, bad;
    n_tests = 0; n_fail = 0; valid_cnt = 0; dbg_cnt = 0; n_cpu_exp = 0; n_dbg_exp = 0;
    rst = 1'b1; inj_ack = 1'b0; mem_lat = 1; mem_never = 0;
    memWriteM = 0; memToRegM = 0; aluOutM = 0; writeDataM = 0;
    dbgReq = 0; dbgWe = 0; dbgAddr = 0; dbgWdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_memReq", 32'(memReq), 32'd0);
    check("rst_stallM", 32'(stallM), 32'd0);
    check("rst_readValid", 32'(readValidM), 32'd0);
    check("rst_dbgAck", 32'(dbgAck), 32'd0);
    check("rst_busErr", 32'(busErr), 32'd0);
    check("rst_readData", readDataM, 32'd0);
    rst = 1'b0;

    // L=1 load of 0x10
    @(negedge clk);
    mem_lat = 1;
    cpu_access(1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 2, 1, "ld1");

    // L=3 store to 0x20
    @(negedge clk);
    mem_lat = 3;
    cpu_access(1'b1, 32'h20, 32'h1234_5678, 32'h0, 4, 3, "st3");
    check("st3_mem", mem_arr[8'h08], 32'h1234_5678);

    // Back-to-back loads with debug pending: 4 CPU grants then debug, twice
    mem_lat = 1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      base = valid_cnt;
      dbg_at = -1;
      fork
        begin
          for (int k = 0; k < 5; k++)
            cpu_access(1'b0, 32'h40 + 32'(4 * k), 32'h0, 32'h1111_0000 + 32'(k),
                       (k < 4) ? 2 : 4, (k < 4) ? 1 : 2, "arb");
        end
        begin
          dbg_access(1'b0, 32'h80, 32'h0, 32'h5555_AAAA, cyc);
          dbg_at = valid_cnt - base;
        end
      join
      check("arb_cpu_before_dbg", 32'(dbg_at), 32'd4);
    end

    // Misaligned CPU load, then misaligned debug read
    @(negedge clk);
    check("mis_busErr_pre", 32'(busErr), 32'd0);
    cpu_access(1'b0, 32'h13, 32'h0, 32'h0, 1, 0, "mis");
    check("mis_busErr", 32'(busErr), 32'd1);
    @(negedge clk);
    dbg_access(1'b0, 32'h02, 32'h0, 32'h0, cyc);
    check("dbgmis_latency", 32'(cyc), 32'd1);

    // Clean reset, then a load that the memory never answers
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_busErr", 32'(busErr), 32'd0);
    @(negedge clk);
    mem_never = 1;
    cpu_access(1'b0, 32'h30, 32'h0, 32'h0, 65, 64, "tmo");
    mem_never = 0;
    check("tmo_busErr", 32'(busErr), 32'd1);
    @(negedge clk); #1;
    check("tmo_valid_once", 32'(readValidM), 32'd0);

    // Reset two cycles into an L=5 load; the late ack must be ignored
    @(negedge clk);
    mem_lat = 5;
    memToRegM = 1'b1; aluOutM = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    check("rstmid_req_pre", 32'(memReq), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rstmid_memReq", 32'(memReq), 32'd0);
    check("rstmid_stallM", 32'(stallM), 32'd0);
    check("rstmid_busErr", 32'(busErr), 32'd0);
    memToRegM = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    inj_ack = 1'b1;
    @(negedge clk);
    inj_ack = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (readValidM || dbgAck || memReq || busErr) bad++;
      @(negedge clk);
    end
    check("late_ack_ignored", 32'(bad), 32'd0);

    check("cpu_completions", 32'(valid_cnt), 32'(n_cpu_exp));
    check("dbg_completions", 32'(dbg_cnt), 32'(n_dbg_exp));
    check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("dbg_q_empty", 32'(dbg_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
